filter_dac_spi: RTL and testbench
=================================

Name: filter_dac_spi

Overview:
- Downstream output stage of the LMS noise filter.
- Consumes each filtered sample (signed 16-bit with a one-cycle valid pulse at the filter clock-enable rate).
- Applies a saturating gain shift, converts the result to an offset-binary DAC code, and serialises it to an external 12-bit SPI DAC in mode 0.
- Holds one pending sample while a frame is in flight; reports overruns through a drop counter.

Parameters:
- CLK_DIV, 2: clk cycles per SCLK half-period; legal range 1..255.
- DAC_BITS, 12: DAC code width; legal range 8..16.
- GAIN_SHIFT, 0: arithmetic left shift applied to the input before conversion, with saturation; legal range 0..8.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- in_s  in  16  signed filtered sample.
- in_valid  in  1  sample strobe, one-cycle pulse.
- dac_cs_n  out  1  SPI chip select, active low.
- dac_sclk  out  1  SPI clock, idle low.
- dac_mosi  out  1  SPI data, MSB first.
- busy  out  1  high whenever state is not IDLE or a sample is pending.
- drop_cnt  out  8  count of overwritten pending samples; saturates at 255.

Behaviour:
- Reset values: dac_cs_n=1, dac_sclk=0, dac_mosi=0, busy=0, drop_cnt=0, pending empty, state=IDLE.
- Reset is honoured mid-frame: the frame is aborted in the same cycle.
- Conversion, evaluated at capture:
  - g = in_s <<< GAIN_SHIFT, computed at 16+GAIN_SHIFT bits and saturated to [-32768, 32767].
  - code = (g >>> (16-DAC_BITS)) with the MSB inverted (equivalently + 2^(DAC_BITS-1), offset binary).
  - Frame word = 16 bits: zero-padded MSBs followed by code.
- Capture: on an edge with in_valid=1, the converted word is written to the pending register and pend_valid is set.
  - If pend_valid was already 1 and is not being consumed on that edge: overwrite (latest wins) and increment drop_cnt (saturating).
  - If the pending register is being consumed on the same edge: the new sample becomes pending, no drop.
- FSM states:
  - IDLE: on an edge with pend_valid=1, load the shift register from pending, clear pend_valid (unless refilled the same edge), set dac_cs_n=0, drive dac_mosi=bit15, go to SHIFT_LO.
  - SHIFT_LO: dac_sclk=0 for CLK_DIV cycles, then dac_sclk=1 and go to SHIFT_HI.
  - SHIFT_HI: dac_sclk=1 for CLK_DIV cycles, then dac_sclk=0.
    - If bits remain: shift, drive the next bit on dac_mosi, go to SHIFT_LO.
    - After bit 0: dac_cs_n=1, dac_mosi=0, go to GAP.
  - GAP: dac_cs_n high for CLK_DIV cycles, then go to IDLE.
- Bit timing: dac_mosi changes only on SCLK falling transitions or at CS assertion, so it is stable across each rising edge.
- Timing:
  - dac_cs_n falls 2 edges after the in_valid edge when IDLE with nothing pending.
  - dac_cs_n stays low for exactly 32*CLK_DIV cycles, with 16 SCLK rising edges.
  - Minimum sample-to-sample frame period is 33*CLK_DIV+1 cycles; it must be ≤ the filter sample period (67 at default vs 128).
- A pending sample captured during a frame starts in the IDLE cycle following GAP; no frames are merged.
- busy = (state != IDLE) | pend_valid.

Test Plan:
- GAIN_SHIFT=0, CLK_DIV=2, single in_s=0x0000 pulse -> one frame of exactly 16 SCLK rises, 64 cycles of cs_n low, bits sampled 0x0800; busy then returns to 0.
- GAIN_SHIFT=0, in_s=0x8000, 0x7FFF, 0x1234 with pulses 128 cycles apart -> frames 0x0000, 0x0FFF, 0x0923; drop_cnt=0.
- GAIN_SHIFT=2, in_s=0x3000, 0xD000, 0x0100 -> saturated frames 0x0FFF and 0x0000, then 0x0840.
- CLK_DIV=2, in_valid pulses at cycles 0, 10, 20, 30 (A, B, C, D) -> A sent, B and C overwritten, D sent next; drop_cnt=2.
- in_valid pulse at cycle 0, then in_valid again on the cycle IDLE consumes pending -> both samples sent back-to-back, drop_cnt=0.
- rst_n asserted low for 1 cycle mid-frame (after the 5th SCLK rise) -> next cycle cs_n=1, sclk=0, mosi=0, busy=0, drop_cnt=0; a following sample produces a clean full frame.

Source files
------------

// File: rtl/filter_dac_spi.sv
// Output stage of the LMS noise filter: saturating gain, offset-binary conversion,
// and a mode-0 SPI serialiser with a one-deep pending slot and overrun counter.
module filter_dac_spi #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned DAC_BITS   = 12,
    parameter int unsigned GAIN_SHIFT = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [15:0] in_s,
    input  logic               in_valid,
    output logic               dac_cs_n,
    output logic               dac_sclk,
    output logic               dac_mosi,
    output logic               busy,
    output logic [7:0]         drop_cnt
);
    localparam int unsigned GW = 16 + GAIN_SHIFT;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT_LO, S_SHIFT_HI, S_GAP} state_t;

    state_t                r_state, w_state_nxt;
    logic [7:0]            r_cnt, w_cnt_nxt;
    logic [3:0]            r_bits, w_bits_nxt;
    logic [15:0]           r_sh, w_sh_nxt;
    logic                  r_cs_n, w_cs_n_nxt;
    logic                  r_sclk, w_sclk_nxt;
    logic [15:0]           r_pend;
    logic                  r_pend_valid;
    logic [7:0]            r_drop;
    logic                  w_consume;
    logic                  w_div_done;

    logic signed [GW-1:0]       w_ext, w_g;
    logic                       w_ovf;
    logic signed [15:0]         w_sat;
    logic signed [DAC_BITS-1:0] w_code;
    logic [15:0]                w_word;

    assign w_ext = GW'(in_s);
    assign w_g   = w_ext <<< GAIN_SHIFT;
    // Overflow whenever the bits above the 16-bit sign position disagree.
    assign w_ovf = !((&w_g[GW-1:15]) || !(|w_g[GW-1:15]));

    always_comb begin
        w_sat = w_g[15:0];
        if (w_ovf) begin
            w_sat = w_g[GW-1] ? 16'sh8000 : 16'sh7FFF;
        end
        w_code = DAC_BITS'(w_sat >>> (16 - DAC_BITS));
        w_word = 16'({~w_code[DAC_BITS-1], w_code[DAC_BITS-2:0]});
    end

    assign w_div_done = (r_cnt == 8'(CLK_DIV - 1));
    assign w_consume  = (r_state == S_IDLE) && r_pend_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bits_nxt  = r_bits;
        w_sh_nxt    = r_sh;
        w_cs_n_nxt  = r_cs_n;
        w_sclk_nxt  = r_sclk;
        case (r_state)
            S_IDLE: begin
                if (r_pend_valid) begin
                    w_sh_nxt    = r_pend;
                    w_bits_nxt  = 4'd15;
                    w_cnt_nxt   = '0;
                    w_cs_n_nxt  = 1'b0;
                    w_sclk_nxt  = 1'b0;
                    w_state_nxt = S_SHIFT_LO;
                end
            end
            S_SHIFT_LO: begin
                if (w_div_done) begin
                    w_cnt_nxt   = '0;
                    w_sclk_nxt  = 1'b1;
                    w_state_nxt = S_SHIFT_HI;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_SHIFT_HI: begin
                if (w_div_done) begin
                    w_cnt_nxt  = '0;
                    w_sclk_nxt = 1'b0;
                    // MOSI is the shifter MSB, so it only moves with the falling SCLK.
                    if (r_bits != 4'd0) begin
                        w_sh_nxt    = {r_sh[14:0], 1'b0};
                        w_bits_nxt  = r_bits - 4'd1;
                        w_state_nxt = S_SHIFT_LO;
                    end else begin
                        w_sh_nxt    = '0;
                        w_cs_n_nxt  = 1'b1;
                        w_state_nxt = S_GAP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_GAP: begin
                if (w_div_done) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bits  <= '0;
            r_sh    <= '0;
            r_cs_n  <= 1'b1;
            r_sclk  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bits  <= w_bits_nxt;
            r_sh    <= w_sh_nxt;
            r_cs_n  <= w_cs_n_nxt;
            r_sclk  <= w_sclk_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_drop       <= '0;
        end else if (in_valid) begin
            r_pend       <= w_word;
            r_pend_valid <= 1'b1;
            if (r_pend_valid && !w_consume && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
        end else if (w_consume) begin
            r_pend_valid <= 1'b0;
        end
    end

    assign dac_cs_n = r_cs_n;
    assign dac_sclk = r_sclk;
    assign dac_mosi = r_sh[15];
    assign busy     = (r_state != S_IDLE) | r_pend_valid;
    assign drop_cnt = r_drop;

endmodule

// File: tb/tb_filter_dac_spi.sv
// Directed bench for filter_dac_spi: frame contents, timing, overrun handling and reset.
module tb_filter_dac_spi;
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic signed [15:0] s0 = '0, s2 = '0;
    logic              iv0 = 1'b0, iv2 = 1'b0;
    logic              cs0, sclk0, mosi0, busy0, cs2, sclk2, mosi2, busy2;
    logic [7:0]        drop0, drop2;
    logic              sel = 1'b0;
    logic              m_cs, m_sclk, m_mosi, m_busy;
    logic [7:0]        m_drop;
    int                cyc = 0;
    int                n_tests = 0;
    int                n_fail = 0;

    filter_dac_spi #(.CLK_DIV(2), .DAC_BITS(12), .GAIN_SHIFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_s(s0), .in_valid(iv0),
        .dac_cs_n(cs0), .dac_sclk(sclk0), .dac_mosi(mosi0), .busy(busy0), .drop_cnt(drop0)
    );

    filter_dac_spi #(.CLK_DIV(2), .DAC_BITS(12), .GAIN_SHIFT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_s(s2), .in_valid(iv2),
        .dac_cs_n(cs2), .dac_sclk(sclk2), .dac_mosi(mosi2), .busy(busy2), .drop_cnt(drop2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        m_cs   = sel ? cs2   : cs0;
        m_sclk = sel ? sclk2 : sclk0;
        m_mosi = sel ? mosi2 : mosi0;
        m_busy = sel ? busy2 : busy0;
        m_drop = sel ? drop2 : drop0;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [15:0] v);
        @(negedge clk);
        if (sel) begin s2 = v; iv2 = 1'b1; end
        else     begin s0 = v; iv0 = 1'b1; end
        @(negedge clk);
        iv0 = 1'b0;
        iv2 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic get_frame(output logic [15:0] word, output int rises, output int lows,
                             output int start, output bit ok);
        int   t;
        logic prev;
        word = '0; rises = 0; lows = 0; start = 0; ok = 1'b0; t = 0;
        while (m_cs !== 1'b0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (m_cs !== 1'b0) return;
        start = cyc;
        prev  = m_sclk;
        while (m_cs === 1'b0 && lows < 2000) begin
            lows++;
            if (m_sclk === 1'b1 && prev === 1'b0) begin
                word = {word[14:0], m_mosi};
                rises++;
            end
            prev = m_sclk;
            @(negedge clk);
        end
        ok = (lows < 2000);
    endtask

    task automatic frame_check(input string tag, input logic [15:0] exp_word);
        logic [15:0] w;
        int r, l, st;
        bit ok;
        get_frame(w, r, l, st, ok);
        check({tag, "_seen"}, 32'(ok), 32'd1);
        check({tag, "_word"}, 32'(w), 32'(exp_word));
        check({tag, "_rises"}, r, 16);
        check({tag, "_cslow"}, l, 64);
    endtask

    initial begin
        logic [15:0] w1, w2;
        int r1, l1, st1, r2, l2, st2, c1, rise5;
        bit ok1, ok2;
        logic [15:0] sv0 [3];
        logic [15:0] ex0 [3];
        logic [15:0] sv2 [3];
        logic [15:0] ex2 [3];
        sv0 = '{16'h8000, 16'h7FFF, 16'h1234};
        ex0 = '{16'h0000, 16'h0FFF, 16'h0923};
        sv2 = '{16'h3000, 16'hD000, 16'h0100};
        ex2 = '{16'h0FFF, 16'h0000, 16'h0840};

        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(m_cs), 32'd1);
        check("rst_sclk", 32'(m_sclk), 32'd0);
        check("rst_mosi", 32'(m_mosi), 32'd0);
        check("rst_busy", 32'(m_busy), 32'd0);
        check("rst_drop", 32'(m_drop), 32'd0);
        rst_n = 1'b1;

        // Single zero sample: mid-scale code, latency and return to idle.
        pulse(16'h0000);
        c1 = cyc;
        check("lat_cs_still_high", 32'(m_cs), 32'd1);
        check("lat_busy_pending", 32'(m_busy), 32'd1);
        get_frame(w1, r1, l1, st1, ok1);
        check("zero_seen", 32'(ok1), 32'd1);
        check("zero_latency", st1 - c1, 1);
        check("zero_word", 32'(w1), 32'h0800);
        check("zero_rises", r1, 16);
        check("zero_cslow", l1, 64);
        check("zero_busy_gap", 32'(m_busy), 32'd1);
        repeat (3) @(negedge clk);
        check("zero_busy_done", 32'(m_busy), 32'd0);

        // Full-scale and ordinary codes at unity gain.
        for (int i = 0; i < 3; i++) begin
            pulse(sv0[i]);
            frame_check($sformatf("g0_%0d", i), ex0[i]);
            repeat (60) @(negedge clk);
        end
        check("g0_drop", 32'(m_drop), 32'd0);

        // Gain of 4 with saturation in both directions.
        sel = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pulse(sv2[i]);
            frame_check($sformatf("g2_%0d", i), ex2[i]);
            repeat (60) @(negedge clk);
        end
        check("g2_drop", 32'(m_drop), 32'd0);
        sel = 1'b0;

        // Overrun: A sent, B and C overwritten, D follows with minimum spacing.
        do_reset();
        fork
            begin
                pulse(16'h1000);
                repeat (8) @(negedge clk);
                pulse(16'h2220);
                repeat (8) @(negedge clk);
                pulse(16'h3330);
                repeat (8) @(negedge clk);
                pulse(16'hF000);
            end
            begin
                get_frame(w1, r1, l1, st1, ok1);
                get_frame(w2, r2, l2, st2, ok2);
            end
        join
        check("ovr_a_seen", 32'({ok1, ok2}), 32'd3);
        check("ovr_a_word", 32'(w1), 32'h0900);
        check("ovr_d_word", 32'(w2), 32'h0700);
        check("ovr_d_rises", r2, 16);
        check("ovr_period", st2 - st1, 67);
        check("ovr_drop", 32'(m_drop), 32'd2);
        repeat (4) @(negedge clk);
        check("ovr_no_third", 32'(m_busy), 32'd0);

        // Refill on the consuming edge: both sent back-to-back, no drop.
        do_reset();
        @(negedge clk);
        s0 = 16'h7FFF; iv0 = 1'b1;
        @(negedge clk);
        s0 = 16'h8000;
        @(negedge clk);
        iv0 = 1'b0;
        get_frame(w1, r1, l1, st1, ok1);
        get_frame(w2, r2, l2, st2, ok2);
        check("b2b_seen", 32'({ok1, ok2}), 32'd3);
        check("b2b_first", 32'(w1), 32'h0FFF);
        check("b2b_second", 32'(w2), 32'h0000);
        check("b2b_period", st2 - st1, 67);
        check("b2b_drop", 32'(m_drop), 32'd0);

        // Reset after the 5th SCLK rise with a pending sample and a drop recorded.
        do_reset();
        rise5 = 0;
        fork
            begin
                pulse(16'h1111);
                pulse(16'h2222);
                pulse(16'h3333);
            end
            begin
                int   t;
                logic p;
                t = 0;
                p = 1'b0;
                while (rise5 < 5 && t < 300) begin
                    @(negedge clk);
                    t++;
                    if (m_sclk === 1'b1 && p === 1'b0) rise5++;
                    p = m_sclk;
                end
            end
        join
        check("mid_rise5", rise5, 5);
        check("mid_drop_before", 32'(m_drop), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_cs_n", 32'(m_cs), 32'd1);
        check("mid_sclk", 32'(m_sclk), 32'd0);
        check("mid_mosi", 32'(m_mosi), 32'd0);
        check("mid_busy", 32'(m_busy), 32'd0);
        check("mid_drop", 32'(m_drop), 32'd0);
        pulse(16'h4000);
        frame_check("post_rst", 16'h0C00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
